// File: rtl/system_pio_out_ext.sv
// Avalon-MM output PIO with atomic SET/CLEAR, shadow->committed double buffering and an optional
// timed XOR pulse engine (enabled by defining SYSTEM_PIO_PULSE_EN).
module system_pio_out_ext #(
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int unsigned           PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  trigger_in,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLEAR = 3'd2;
  localparam logic [2:0] ADDR_CTRL  = 3'd3;
  localparam logic [2:0] ADDR_MASK  = 3'd4;
  localparam logic [2:0] ADDR_LEN   = 3'd5;

  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] committed;
  logic [DATA_WIDTH-1:0] shadow_nxt;
  logic                  sync_mode;
  logic                  pending;
  logic                  trig_q;
  logic                  pulse_active;
  logic [BUS_W-1:0]      mask_rd;
  logic [BUS_W-1:0]      cnt_rd;

  logic wr_c;
  logic data_wr_c;
  logic ctrl_wr_c;
  logic commit_c;

  assign wr_c      = chipselect & ~write_n;
  assign data_wr_c = wr_c & (address <= ADDR_CLEAR);
  assign ctrl_wr_c = wr_c & (address == ADDR_CTRL);

  // A commit copies the pre-edge shadow; a CTRL write that leaves sync mode flushes anything pending.
  assign commit_c = (sync_mode & trigger_in & ~trig_q)
                  | (ctrl_wr_c & (writedata[1] | (~writedata[0] & pending)));

  always_comb begin
    shadow_nxt = shadow;
    case (address)
      ADDR_DATA:  shadow_nxt = writedata[DATA_WIDTH-1:0];
      ADDR_SET:   shadow_nxt = shadow | writedata[DATA_WIDTH-1:0];
      ADDR_CLEAR: shadow_nxt = shadow & ~writedata[DATA_WIDTH-1:0];
      default:    shadow_nxt = shadow;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow    <= RESET_VALUE;
      committed <= RESET_VALUE;
      sync_mode <= 1'b0;
      pending   <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      trig_q <= trigger_in;
      if (ctrl_wr_c) sync_mode <= writedata[0];
      if (commit_c) begin
        committed <= shadow;
        pending   <= 1'b0;
      end
      // A same-edge register write lands in shadow after the commit sampled it
      if (data_wr_c) begin
        shadow <= shadow_nxt;
        if (!sync_mode) committed <= shadow_nxt;
        else            pending   <= 1'b1;
      end
    end
  end

`ifdef SYSTEM_PIO_PULSE_EN
  logic [DATA_WIDTH-1:0]      mask;
  logic [PULSE_CNT_WIDTH-1:0] cnt;

  assign pulse_active = |cnt;

  // A LEN write (re)starts or aborts the pulse; otherwise count down while active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      cnt  <= '0;
    end else begin
      if (wr_c && address == ADDR_MASK) mask <= writedata[DATA_WIDTH-1:0];
      if (wr_c && address == ADDR_LEN)  cnt  <= writedata[PULSE_CNT_WIDTH-1:0];
      else if (pulse_active)            cnt  <= cnt - PULSE_CNT_WIDTH'(1);
    end
  end

  assign mask_rd  = BUS_W'(mask);
  assign cnt_rd   = BUS_W'(cnt);
  assign out_port = committed ^ (pulse_active ? mask : '0);
`else
  assign pulse_active = 1'b0;
  assign mask_rd      = '0;
  assign cnt_rd       = '0;
  assign out_port     = committed;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata = BUS_W'(committed);
      ADDR_SET:   readdata = BUS_W'(shadow);
      ADDR_CLEAR: readdata = BUS_W'(shadow);
      ADDR_CTRL:  readdata = {29'b0, pulse_active, pending, sync_mode};
      ADDR_MASK:  readdata = mask_rd;
      ADDR_LEN:   readdata = cnt_rd;
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_system_pio_out_ext.sv
// Directed and randomized checks of system_pio_out_ext against a cycle-level behavioural model.
// Pulse checks are compiled in only when SYSTEM_PIO_PULSE_EN is defined.
module tb_system_pio_out_ext;

  localparam int unsigned DW  = 32;
  localparam int unsigned PCW = 16;
  localparam logic [31:0] RV  = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        trigger_in;
  logic [31:0] out_port;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] m_shadow, m_comm, m_mask;
  logic        m_sync, m_pend, m_trig_prev;
  int unsigned m_cnt;

  system_pio_out_ext #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .PULSE_CNT_WIDTH(PCW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .trigger_in(trigger_in), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pulse_on();
`ifdef SYSTEM_PIO_PULSE_EN
    return m_cnt != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_out();
    return pulse_on() ? (m_comm ^ m_mask) : m_comm;
  endfunction

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0:    return m_comm;
      3'd1,
      3'd2:    return m_shadow;
      3'd3:    return {29'b0, pulse_on(), m_pend, m_sync};
`ifdef SYSTEM_PIO_PULSE_EN
      3'd4:    return m_mask;
      3'd5:    return m_cnt;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_shadow = RV; m_comm = RV; m_mask = 0;
    m_sync = 0; m_pend = 0; m_trig_prev = 0; m_cnt = 0;
  endtask

  // Apply one clock of the register-level rules to the model
  task automatic model_clock(input bit wr, input logic [2:0] a, input logic [31:0] wd, input bit trig);
    logic [31:0] new_sh;
    bit commit;
    commit = 0;
    if (wr && a == 3 && (wd[1] || (!wd[0] && m_pend))) commit = 1;
    if (m_sync && trig && !m_trig_prev) commit = 1;
    new_sh = (a == 0) ? wd : (a == 1) ? (m_shadow | wd) : (m_shadow & ~wd);
    if (commit) begin m_comm = m_shadow; m_pend = 0; end
    if (wr && a <= 2) begin
      if (!m_sync) m_comm = new_sh;
      else m_pend = 1;
      m_shadow = new_sh;
    end
    if (wr && a == 3) m_sync = wd[0];
    m_trig_prev = trig;
    if (wr && a == 4) m_mask = wd;
    if (wr && a == 5) m_cnt = wd % (32'd1 << PCW);
    else if (m_cnt != 0) m_cnt = m_cnt - 1;
  endtask

  // One clock: drive bus, check out_port after the edge, then probe readdata at rd_a
  task automatic step(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd,
                      input bit trig, input logic [2:0] rd_a);
    chipselect = cs; write_n = wn; address = a; writedata = wd; trigger_in = trig;
    model_clock(cs & ~wn, a, wd, trig);
    @(posedge clk);
    @(negedge clk);
    chk("out_port", out_port, model_out());
    chipselect = 0; write_n = 1; address = rd_a;
    #1;
    chk($sformatf("rd_addr%0d", rd_a), readdata, model_rd(rd_a));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input bit trig, input logic [2:0] rd_a);
    step(1, 0, a, wd, trig, rd_a);
  endtask

  task automatic idle(input bit trig, input logic [2:0] rd_a);
    step(0, 1, 3'd0, 32'h0, trig, rd_a);
  endtask

  initial begin
    reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; trigger_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out", out_port, 32'hA5);
    address = 0; #1; chk("reset_rd0", readdata, 32'hA5);
    address = 3; #1; chk("reset_rd3", readdata, 32'h0);
    reset_n = 1;

    // immediate mode
    wr(0, 32'h0F, 0, 0); chk("imm_data", out_port, 32'h0F);
    wr(1, 32'hF0, 0, 0); chk("imm_set", out_port, 32'hFF);
    wr(2, 32'h03, 0, 0); chk("imm_clear", out_port, 32'hFC);

    // sync mode with trigger
    wr(3, 32'h1, 0, 3);
    wr(0, 32'h55, 0, 3); chk("sync_hold", out_port, 32'hFC); chk("sync_ctrl", readdata, 32'h3);
    idle(1, 3);          chk("trig_commit", out_port, 32'h55); chk("trig_pend", readdata, 32'h1);
    wr(0, 32'h66, 1, 0); chk("trig_held", out_port, 32'h55);
    idle(1, 0);          chk("trig_held2", out_port, 32'h55);
    idle(0, 0);
    idle(1, 0);          chk("trig_rise2", out_port, 32'h66);

    // write and commit on the same edge
    wr(0, 32'h55, 0, 1);
    wr(0, 32'h77, 1, 1); chk("same_edge_comm", out_port, 32'h55); chk("same_edge_shadow", readdata, 32'h77);
    address = 3; #1; chk("same_edge_pend", readdata, 32'h3);

    // software commit, then leave sync mode (flushes pending)
    idle(0, 0);
    wr(0, 32'h11, 0, 0);
    wr(3, 32'h3, 0, 0);  chk("sw_commit", out_port, 32'h11);
    wr(1, 32'h22, 0, 3);
    wr(3, 32'h0, 0, 3);  chk("exit_sync", out_port, 32'h33);

`ifdef SYSTEM_PIO_PULSE_EN
    wr(0, 32'h00, 0, 0);
    wr(4, 32'h01, 0, 4);
    wr(5, 32'd3, 0, 5); chk("pulse_on", out_port, 32'h01); chk("pulse_cnt3", readdata, 32'd3);
    idle(0, 5);         chk("pulse_cnt2", readdata, 32'd2);
    idle(0, 5);         chk("pulse_cnt1", readdata, 32'd1); chk("pulse_last", out_port, 32'h01);
    idle(0, 5);         chk("pulse_cnt0", readdata, 32'd0); chk("pulse_off", out_port, 32'h00);
    wr(5, 32'd3, 0, 5);
    idle(0, 5); idle(0, 5);
    wr(5, 32'd5, 0, 5); chk("pulse_restart", readdata, 32'd5);
    repeat (4) idle(0, 5);
    chk("pulse_restart_on", out_port, 32'h01);
    idle(0, 5);         chk("pulse_restart_off", out_port, 32'h00);
    wr(5, 32'd9, 0, 5);
    idle(0, 5);
    wr(5, 32'd0, 0, 5); chk("pulse_abort", out_port, 32'h00);
    wr(5, 32'h0001_0004, 0, 5); chk("pulse_trunc", readdata, 32'd4);
    wr(3, 32'h1, 0, 3);
    wr(0, 32'h12, 0, 3);
    @(negedge clk);
    model_clock(0, 0, 0, 0);
    chk("pre_reset_pulse", out_port, model_out());
`else
    wr(4, 32'hFF, 0, 4); chk("no_mask", readdata, 32'h0);
    wr(5, 32'd7, 0, 5);  chk("no_len", readdata, 32'h0); chk("no_pulse", out_port, 32'h33);
    wr(3, 32'h1, 0, 3);
    wr(0, 32'h12, 0, 3);
    @(negedge clk);
    model_clock(0, 0, 0, 0);
`endif

    // asynchronous reset away from any clock edge
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("async_out", out_port, 32'hA5);
    address = 3; #1; chk("async_ctrl", readdata, 32'h0);
    address = 5; #1; chk("async_len", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom();
      if (a == 5) wd = (($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 6))) | (wd & 32'hFFFF_0000);
      if (a == 3 && $urandom_range(0, 1) == 1) wd = wd & 32'h1;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, wd,
           $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
